frame_config_writer: RTL



---
 rtl/frame_config_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/frame_config_writer.sv
// ============================================================================
// frame_config_writer: parses a 32-bit config word stream into frame writes
// and drives FrameData / one-hot FrameStrobe.
// Optional: FRAME_WRITER_PARITY_EN adds a trailing XOR check word per frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_config_writer #(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumberOfRows    = 4,
    parameter int          NumberOfCols    = 4,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                                    UserCLK,
    input  logic                                    Reset,
    input  logic [31:0]                             WriteData,
    input  logic                                    WriteValid,
    output logic                                    WriteReady,
    output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
    output logic [MaxFramesPerCol*NumberOfCols-1:0] FrameStrobe,
    output logic                                    ConfigActive,
    output logic                                    ConfigDone,
    output logic                                    ErrorFlag
);

    localparam int StrobeW = MaxFramesPerCol * NumberOfCols;
    localparam int RowW    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

    localparam logic [3:0] OpDesync = 4'h0;
    localparam logic [3:0] OpWrite  = 4'h1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_DATA   = 3'd2,
`ifdef FRAME_WRITER_PARITY_EN
        S_CHECK  = 3'd3,
`endif
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t            state;
    logic [RowW-1:0]   row_cnt;
    logic [7:0]        col;
    logic [4:0]        frame;
    logic              drop;
`ifdef FRAME_WRITER_PARITY_EN
    logic [31:0]       parity_acc;
`endif

    logic              xfer;
    logic [3:0]        hdr_op;
    logic [7:0]        hdr_col;
    logic [4:0]        hdr_frame;
    logic              hdr_bad;
    logic              last_row;
    logic [31:0]       strobe_idx;
    logic [StrobeW-1:0] strobe_onehot;

    always_comb begin
        WriteReady = (state == S_IDLE) || (state == S_HDR) || (state == S_DATA);
`ifdef FRAME_WRITER_PARITY_EN
        WriteReady = WriteReady || (state == S_CHECK);
`endif
    end

    assign xfer          = WriteValid && WriteReady;
    assign hdr_op        = WriteData[31:28];
    assign hdr_col       = WriteData[19:12];
    assign hdr_frame     = WriteData[4:0];
    assign hdr_bad       = ({24'd0, hdr_col} >= 32'(NumberOfCols)) ||
                           ({27'd0, hdr_frame} >= 32'(MaxFramesPerCol));
    assign last_row      = (row_cnt == RowW'(NumberOfRows - 1));
    assign strobe_idx    = 32'(col) * 32'(MaxFramesPerCol) + 32'(frame);
    assign strobe_onehot = StrobeW'(1) << strobe_idx;

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state        <= S_IDLE;
            row_cnt      <= '0;
            col          <= '0;
            frame        <= '0;
            drop         <= 1'b0;
            FrameData    <= '0;
            FrameStrobe  <= '0;
            ConfigActive <= 1'b0;
            ConfigDone   <= 1'b0;
            ErrorFlag    <= 1'b0;
`ifdef FRAME_WRITER_PARITY_EN
            parity_acc   <= '0;
`endif
        end else begin
            ConfigDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xfer && WriteData == SyncWord) begin
                        state        <= S_HDR;
                        ConfigActive <= 1'b1;
                    end
                end
                S_HDR: begin
                    // A repeated sync word is simply skipped while in HDR.
                    if (xfer && WriteData != SyncWord) begin
                        if (hdr_op == OpWrite) begin
                            state   <= S_DATA;
                            row_cnt <= '0;
                            col     <= hdr_col;
                            frame   <= hdr_frame;
                            drop    <= hdr_bad;
`ifdef FRAME_WRITER_PARITY_EN
                            parity_acc <= '0;
`endif
                            if (hdr_bad)
                                ErrorFlag <= 1'b1;
                        end else if (hdr_op == OpDesync) begin
                            state        <= S_IDLE;
                            ConfigActive <= 1'b0;
                            ConfigDone   <= 1'b1;
                        end else begin
                            ErrorFlag <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        FrameData[32'(row_cnt)*FrameBitsPerRow +: FrameBitsPerRow]
                            <= FrameBitsPerRow'(WriteData);
                        row_cnt <= row_cnt + RowW'(1);
`ifdef FRAME_WRITER_PARITY_EN
                        parity_acc <= parity_acc ^ WriteData;
                        if (last_row)
                            state <= S_CHECK;
`else
                        if (last_row) begin
                            state       <= S_STROBE;
                            FrameStrobe <= drop ? '0 : strobe_onehot;
                        end
`endif
                    end
                end
`ifdef FRAME_WRITER_PARITY_EN
                S_CHECK: begin
                    if (xfer) begin
                        state <= S_STROBE;
                        if (WriteData != parity_acc) begin
                            ErrorFlag   <= 1'b1;
                            FrameStrobe <= '0;
                        end else begin
                            FrameStrobe <= drop ? '0 : strobe_onehot;
                        end
                    end
                end
`endif
                S_STROBE: begin
                    state       <= S_HOLD;
                    FrameStrobe <= '0;
                end
                S_HOLD: begin
                    state <= S_HDR;
                end
                default: begin
                    state       <= S_IDLE;
                    FrameStrobe <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
